// File: rtl/interboard_pkg.sv
// Shared definitions for the interboard link: message type codes, beat
// layout, queued-message layout and the transmit FSM state encoding.
package interboard_pkg;

   // Message type codes shared with the receiver and the game FSMs
   localparam logic [2:0] MSG_NOP    = 3'd0;
   localparam logic [2:0] MSG_HELLO  = 3'd1;
   localparam logic [2:0] MSG_MOVE   = 3'd2;
   localparam logic [2:0] MSG_RESULT = 3'd3;
   localparam logic [2:0] MSG_TURN   = 3'd4;
   localparam logic [2:0] MSG_SYNC   = 3'd5;
   localparam logic [2:0] MSG_ERROR  = 3'd6;
   localparam logic [2:0] MSG_RESET  = 3'd7;

   // Beat layout: bit 5 marks the header (first) beat of a message
   localparam int BEAT_W   = 6;
   localparam int BEAT_HDR = 5;

   // Queued message layout: {en, msg_type[2:0], number[4:0]}
   localparam int MSG_W = 9;

   // Transmit FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_REQ_HI = 2'd2;
   localparam logic [1:0] ST_REQ_LO = 2'd3;

   function automatic logic [MSG_W-1:0] pack_msg(input logic en, input logic [2:0] msg_type,
                                                 input logic [4:0] number);
      return {en, msg_type, number};
   endfunction

   function automatic logic msg_en(input logic [MSG_W-1:0] msg);
      return msg[8];
   endfunction

   function automatic logic [2:0] msg_type_of(input logic [MSG_W-1:0] msg);
      return msg[7:5];
   endfunction

   function automatic logic [4:0] msg_number(input logic [MSG_W-1:0] msg);
      return msg[4:0];
   endfunction

   // Header beat: {hdr=1, en, 0, msg_type}
   function automatic logic [BEAT_W-1:0] pack_beat0(input logic en, input logic [2:0] msg_type);
      return {1'b1, en, 1'b0, msg_type};
   endfunction

   // Payload beat: {hdr=0, number}
   function automatic logic [BEAT_W-1:0] pack_beat1(input logic [4:0] number);
      return {1'b0, number};
   endfunction

endpackage

// File: rtl/interboard_msg_fifo.sv
// Small synchronous message queue. Show-ahead read: the head entry is
// visible on o_data whenever the queue is non-empty, so the consumer can
// use it in the same cycle it pops. A push while full is accepted only
// when a pop in the same cycle frees the slot.
module interboard_msg_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   // Storage write; contents need no reset because count gates validity
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/interboard_tx.sv
// Transmit stage of the interboard link. Queues controller messages,
// splits each into a header beat and a payload beat, and presents them to
// the peer with a 4-phase Request_out/Ack_in handshake. Each Ack_in edge
// is awaited for at most ACK_TIMEOUT cycles; a stalled message is dropped.
module interboard_tx
   import interboard_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int ACK_TIMEOUT  = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmit,
   input  logic       ctrl_en,
   input  logic [2:0] ctrl_msg_type,
   input  logic [4:0] ctrl_number,
   input  logic       Ack_in,
   output logic       Request_out,
   output logic [5:0] inter_data_out,
   output logic       inter_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_timeout,
   output logic       tx_overflow
);

   localparam int TO_W = $clog2(ACK_TIMEOUT);
   localparam int SU_W = $clog2(SETUP_CYCLES + 1);

   logic              r_ack_meta;
   logic              r_ack_s;
   logic [1:0]        r_state;
   logic              r_beat;
   logic [SU_W-1:0]   r_setup_cnt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [BEAT_W-1:0] r_data;
   logic [4:0]        r_number;
   logic              r_req;
   logic              r_done;
   logic              r_timeout;
   logic              r_overflow;

   logic [MSG_W-1:0]  w_msg_in;
   logic [MSG_W-1:0]  w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;

   assign w_msg_in = pack_msg(ctrl_en, ctrl_msg_type, ctrl_number);

   // A new message is taken only when idle and the peer has released Ack;
   // a stale high ack holds the queue until it falls.
   assign w_pop = (r_state == ST_IDLE) && !w_empty && !r_ack_s;

   interboard_msg_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (MSG_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (transmit),
      .i_data  (w_msg_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Two-flop synchroniser for the asynchronous peer acknowledge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack_meta <= 1'b0;
         r_ack_s    <= 1'b0;
      end else begin
         r_ack_meta <= Ack_in;
         r_ack_s    <= r_ack_meta;
      end
   end

   // Flag a dropped message: push while full with no pop freeing a slot
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= transmit && w_full && !w_pop;
      end
   end

   // Handshake FSM: setup hold, raise request, wait ack high, drop request,
   // wait ack low; twice per message. Timer restarts on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_beat      <= 1'b0;
         r_setup_cnt <= '0;
         r_to_cnt    <= '0;
         r_data      <= '0;
         r_number    <= '0;
         r_req       <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_data      <= pack_beat0(msg_en(w_head), msg_type_of(w_head));
                  r_number    <= msg_number(w_head);
                  r_beat      <= 1'b0;
                  r_setup_cnt <= '0;
                  r_to_cnt    <= '0;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_setup_cnt == SU_W'(SETUP_CYCLES - 1)) begin
                  r_req    <= 1'b1;
                  r_to_cnt <= '0;
                  r_state  <= ST_REQ_HI;
               end else begin
                  r_setup_cnt <= r_setup_cnt + SU_W'(1);
               end
            end
            ST_REQ_HI: begin
               if (r_ack_s) begin
                  r_req    <= 1'b0;
                  r_to_cnt <= '0;
                  r_state  <= ST_REQ_LO;
               end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                  r_req     <= 1'b0;
                  r_timeout <= 1'b1;
                  r_to_cnt  <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            ST_REQ_LO: begin
               if (!r_ack_s) begin
                  r_to_cnt <= '0;
                  if (!r_beat) begin
                     r_data      <= pack_beat1(r_number);
                     r_beat      <= 1'b1;
                     r_setup_cnt <= '0;
                     r_state     <= ST_SETUP;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                  r_timeout <= 1'b1;
                  r_to_cnt  <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Request_out    = r_req;
   assign inter_data_out = r_data;
   assign tx_done        = r_done;
   assign tx_timeout     = r_timeout;
   assign tx_overflow    = r_overflow;
   assign inter_ready    = !w_full;
   assign tx_busy        = (r_state != ST_IDLE) || !w_empty;

endmodule
